// File: rtl/data_memory_ctrl.sv
// Single-port synchronous-read data RAM with a hardware init walker that loads reset values after reset or on Clr.
// Latency: 1 cycle read and write. Backpressure: Busy blocks the CPU port while the walker runs; writes seen then pulse Wr_drop.
module data_memory_ctrl #(
    parameter int                DATA_W       = 8,
    parameter int                ADDR_W       = 5,
    parameter int                SPECIAL_ADDR = 27,
    parameter logic [DATA_W-1:0] SPECIAL_INIT = '1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              En,
    input  logic              Rd,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] Data_in,
    input  logic              Clr,
    output logic [DATA_W-1:0] Data_out,
    output logic              Rd_valid,
    output logic              Busy,
    output logic              Wr_drop
);
    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] SPECIAL_A = ADDR_W'(SPECIAL_ADDR);
    localparam logic [ADDR_W-1:0] LAST_A    = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              rd_valid_q, rd_valid_d;
    logic              wr_drop_q, wr_drop_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        rd_valid_d = 1'b0;
        wr_drop_d  = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = Address;
        mem_wdata  = Data_in;
        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = (cnt_q == SPECIAL_A) ? SPECIAL_INIT : '0;
                wr_drop_d = En;
                if (cnt_q == LAST_A) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                // Write-first on the shared address, unless Clr discards the write.
                if (Rd) begin
                    rd_valid_d = 1'b1;
                    dout_d     = (En && !Clr) ? Data_in : mem[Address];
                end
                if (Clr) begin
                    state_d   = ST_INIT;
                    cnt_d     = '0;
                    wr_drop_d = En;
                end else begin
                    mem_we = En;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            dout_q     <= '0;
            rd_valid_q <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            rd_valid_q <= rd_valid_d;
            wr_drop_q  <= wr_drop_d;
        end
    end

    // Array has no reset; the walker overwrites every word after reset.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign Data_out = dout_q;
    assign Rd_valid = rd_valid_q;
    assign Wr_drop  = wr_drop_q;
    assign Busy     = (state_q == ST_INIT);

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Randomized scoreboard bench for data_memory_ctrl (default build plus a 16x64 build).
module tb_data_memory_ctrl;
    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, rd, clr, rd_valid, busy, wr_drop;
    logic [4:0] addr;
    logic [7:0] din, dout;

    logic        rst2_n, en2, rd2, clr2, rd_valid2, busy2, wr_drop2;
    logic [5:0]  addr2;
    logic [15:0] din2, dout2;

    data_memory_ctrl dut (
        .Clk(clk), .Reset_n(rst_n), .En(en), .Rd(rd), .Address(addr), .Data_in(din),
        .Clr(clr), .Data_out(dout), .Rd_valid(rd_valid), .Busy(busy), .Wr_drop(wr_drop)
    );

    data_memory_ctrl #(.DATA_W(16), .ADDR_W(6), .SPECIAL_ADDR(63)) dut2 (
        .Clk(clk), .Reset_n(rst2_n), .En(en2), .Rd(rd2), .Address(addr2), .Data_in(din2),
        .Clr(clr2), .Data_out(dout2), .Rd_valid(rd_valid2), .Busy(busy2), .Wr_drop(wr_drop2)
    );

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] ref_mem [32];
    logic [7:0] sb [$];
    logic [7:0] exp_last;
    logic [7:0] popped;
    int         m_left;
    bit         mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_init();
        for (int i = 0; i < 32; i++) ref_mem[i] = (i == 27) ? 8'hFF : 8'h00;
    endfunction

    // Monitor: every Rd_valid pops one expected word; otherwise Data_out must hold.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rd_valid", 32'd1, 32'd0);
                end else begin
                    popped = sb.pop_front();
                    chk("rd_data", {24'd0, dout}, {24'd0, popped});
                    exp_last = popped;
                end
            end else begin
                chk("dout_hold", {24'd0, dout}, {24'd0, exp_last});
            end
        end
    end

    // One clock of stimulus; the model decides what the edge should have done.
    task automatic step(input logic e, input logic r, input logic c,
                        input logic [4:0] a, input logic [7:0] d);
        logic exp_drop;
        en = e; rd = r; clr = c; addr = a; din = d;
        @(posedge clk);
        exp_drop = 1'b0;
        if (m_left > 0) begin
            exp_drop = e;
            m_left--;
            if (m_left == 0) ref_init();
        end else begin
            if (r) sb.push_back((e && !c) ? d : ref_mem[a]);
            if (c) begin
                exp_drop = e;
                m_left   = 32;
            end else if (e) begin
                ref_mem[a] = d;
            end
        end
        #1;
        chk("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
        chk("wr_drop", {31'd0, wr_drop}, {31'd0, exp_drop});
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; rd = 1'b0; clr = 1'b0;
        sb.delete();
        exp_last = 8'h00;
        m_left   = 32;
        #2;
        mon_en = 1'b1;
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_dout", {24'd0, dout}, 32'd0);
        chk("rst_wr_drop", {31'd0, wr_drop}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic sweep();
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 1'b0, 5'(i), 8'h00);
        step(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    endtask

    initial begin
        int n;
        rst_n = 1'b1; en = 1'b0; rd = 1'b0; clr = 1'b0; addr = '0; din = '0;
        rst2_n = 1'b0; en2 = 1'b0; rd2 = 1'b0; clr2 = 1'b0; addr2 = '0; din2 = '0;
        #1;
        do_reset();

        // Walk after reset, with ignored CPU traffic, then full read sweep.
        for (int i = 0; i < 32; i++)
            step(i % 3 == 0, i % 2 == 0, i == 5, 5'($urandom), 8'($urandom));
        sweep();

        // Directed: write/read, write-first, Clr with dropped write.
        step(1'b1, 1'b0, 1'b0, 5'd3, 8'h5A);
        step(1'b0, 1'b1, 1'b0, 5'd3, 8'h00);
        step(1'b0, 1'b1, 1'b0, 5'd4, 8'h00);
        step(1'b1, 1'b1, 1'b0, 5'd7, 8'hC3);
        step(1'b1, 1'b0, 1'b0, 5'd27, 8'h11);
        step(1'b0, 1'b1, 1'b0, 5'd27, 8'h00);
        step(1'b1, 1'b1, 1'b1, 5'd2, 8'h77);
        for (int i = 0; i < 32; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 8'($urandom));
        step(1'b0, 1'b1, 1'b0, 5'd27, 8'h00);
        step(1'b0, 1'b1, 1'b0, 5'd2, 8'h00);

        // Reset in the middle of the walk.
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        do_reset();
        for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        sweep();

        // Random traffic with occasional Clr.
        for (int i = 0; i < 400; i++)
            step(1'($urandom), 1'($urandom), ($urandom_range(0, 49) == 0),
                 5'($urandom), 8'($urandom));
        for (int i = 0; i < 33; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        sweep();
        chk("sb_empty", sb.size(), 32'd0);

        // Wide/deep build.
        #2;
        chk("w_rst_busy", {31'd0, busy2}, 32'd1);
        chk("w_rst_rd_valid", {31'd0, rd_valid2}, 32'd0);
        chk("w_rst_dout", {16'd0, dout2}, 32'd0);
        @(posedge clk);
        #1;
        rst2_n = 1'b1;
        n = 0;
        while (busy2 === 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("w_busy_len", n, 32'd64);
        rd2 = 1'b1; addr2 = 6'd63;
        @(posedge clk); #1;
        chk("w_rv63", {31'd0, rd_valid2}, 32'd1);
        chk("w_rd63", {16'd0, dout2}, 32'hFFFF);
        rd2 = 1'b0; en2 = 1'b1; addr2 = 6'd40; din2 = 16'hBEEF;
        @(posedge clk); #1;
        chk("w_rv_idle", {31'd0, rd_valid2}, 32'd0);
        en2 = 1'b0; rd2 = 1'b1;
        @(posedge clk); #1;
        chk("w_rv40", {31'd0, rd_valid2}, 32'd1);
        chk("w_rd40", {16'd0, dout2}, 32'hBEEF);
        addr2 = 6'd0;
        @(posedge clk); #1;
        chk("w_rd0", {16'd0, dout2}, 32'h0000);
        rd2 = 1'b0;
        @(posedge clk); #1;
        chk("w_hold", {16'd0, dout2}, 32'h0000);
        chk("w_rv_off", {31'd0, rd_valid2}, 32'd0);
        chk("w_wr_drop", {31'd0, wr_drop2}, 32'd0);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised successor to the CPU data memory: a single-port, synchronous-read RAM of DEPTH words of DATA_W bits, with a built-in initialisation sequencer that loads per-address reset values after reset or on command. Sits between the CPU datapath (load/store unit) and the register-file writeback mux. It replaces per-word asynchronously reset registers with an array that is cleared by a hardware walker. A single special address (stack-pointer slot) initialises to SPECIAL_INIT; all other addresses initialise to zero.

## Interface
Parameters:
- DATA_W, 8, word width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W words
- SPECIAL_ADDR, 27 (0x1B), address loaded with SPECIAL_INIT during init
- SPECIAL_INIT, all ones, init value for SPECIAL_ADDR

Ports:
- Clk  in  1  clock; all state changes on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- En  in  1  write enable for Address/Data_in
- Rd  in  1  read request
- Address  in  ADDR_W  word address, shared by read and write
- Data_in  in  DATA_W  write data
- Clr  in  1  start re-initialisation (single-cycle pulse sufficient)
- Data_out  out  DATA_W  registered read data
- Rd_valid  out  1  Data_out updated this cycle
- Busy  out  1  init sequencer running; CPU port blocked
- Wr_drop  out  1  one-cycle pulse: a requested write was discarded

## Operation
- FSM states: INIT, IDLE. Reset_n low forces INIT, walk counter = 0, Data_out = 0, Rd_valid = 0, Wr_drop = 0, Busy = 1. Array contents are not reset asynchronously.
- INIT: each rising edge writes mem[cnt] = (cnt == SPECIAL_ADDR) ? SPECIAL_INIT : 0, then cnt+1. On the edge writing cnt = DEPTH-1, go to IDLE and clear cnt to 0. Busy = 1 throughout INIT.
- INIT, CPU side: En ignored, with Wr_drop = 1 on the next cycle for each dropped write. Rd ignored: Rd_valid = 0 and Data_out holds. Clr ignored; the walk is not restarted.
- IDLE, En=1: mem[Address] <= Data_in.
- IDLE, Rd=1: Data_out <= mem[Address], Rd_valid = 1 next cycle. Rd=0 gives Rd_valid = 0 and Data_out holds its last value.
- IDLE, Rd and En on the same address in the same cycle: write-first. Data_out returns the new Data_in.
- IDLE, Clr=1: go to INIT, cnt = 0. A read in the same cycle is serviced with pre-clear contents. A write in the same cycle is dropped (Wr_drop pulse).
- Address is always in range because DEPTH = 2**ADDR_W; no wrap logic.

## Timing
- Read latency: 1 cycle, from the edge sampling Rd to Data_out/Rd_valid valid.
- Write latency: 1 cycle. A read of the same address on the following cycle returns the new value.
- After Reset_n deassertion: Busy stays high for exactly DEPTH rising edges, then falls. The first CPU access is accepted on edge DEPTH+1.
- After Clr accepted in IDLE: Busy rises next cycle and stays high for DEPTH cycles.
- Reset_n asserted mid-INIT or mid-access: immediate return to reset state and the walk restarts from address 0. A partially written array is legal because the walk overwrites every word.
- Wr_drop and Rd_valid are single-cycle pulses per request, with no accumulation.

## Test plan
- Reset release, default parameters: Busy high for 32 edges. Afterwards, reading addresses 0..31 gives 0x00 everywhere except 0x1B = 0xFF, each with Rd_valid one cycle after Rd.
- IDLE write 0x5A to addr 3, then read addr 3 next cycle: Data_out = 0x5A, Rd_valid = 1. Read addr 4 gives 0x00.
- Same-cycle En+Rd at addr 7 with Data_in 0xC3: Data_out = 0xC3 on the next cycle (write-first).
- Write 0x11 to addr 0x1B, then pulse Clr together with En to addr 2: Wr_drop = 1, Busy high for 32 cycles. Afterwards addr 0x1B = 0xFF and addr 2 = 0x00.
- Assert Reset_n low at walk count 10, release: Busy restarts and lasts a full 32 cycles, Data_out = 0, Rd_valid = 0. Final contents match the default init.
- DATA_W=16, ADDR_W=6, SPECIAL_ADDR=63: Busy lasts 64 cycles, addr 63 reads 0xFFFF, write/read 0xBEEF at addr 40 round-trips.
